// File: rtl/score_text_buffer.sv
// rtl/score_text_buffer.sv - score overlay character source with vblank-atomic decimal update
module score_text_buffer #(
    parameter int SCORE_ROW        = 0,
    parameter int PLAYER_DIGIT_COL = 5,
    parameter int CPU_DIGIT_COL    = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] char_xy,
    output logic [6:0]  char_code,
    input  logic        vblnk,
    input  logic        score_update,
    input  logic [7:0]  score_player,
    input  logic [7:0]  score_cpu,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        CONV_P,
        CONV_C,
        FORMAT,
        WAIT_VBLNK,
        COMMIT
    } state_t;

    localparam logic [3:0]  ROW    = 4'(SCORE_ROW);
    localparam logic [7:0]  P_LBL  = 8'(PLAYER_DIGIT_COL - 5);
    localparam logic [7:0]  P_DIG  = 8'(PLAYER_DIGIT_COL);
    localparam logic [7:0]  C_LBL  = 8'(CPU_DIGIT_COL - 5);
    localparam logic [7:0]  C_DIG  = 8'(CPU_DIGIT_COL);
    localparam logic [20:0] DIGITS_RST = {7'h20, 7'h20, 7'h30};

    state_t       state, state_nx;
    logic [19:0]  work;        // {bcd[11:0], binary[7:0]} double-dabble shift register
    logic [19:0]  work_step;
    logic [2:0]   iter;
    logic [7:0]   cpu_lat;
    logic [11:0]  bcd_p;
    logic [7:0]   pend_p, pend_c;
    logic         pending;
    logic [20:0]  shadow_p, shadow_c;
    logic [20:0]  disp_p, disp_c;

    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[8+4*i +: 4] >= 4'd5)
                a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    // Leading-zero blanking; the units digit is always drawn.
    function automatic logic [20:0] fmt(input logic [11:0] b);
        logic [6:0] h, t, u;
        h = (b[11:8] == 4'd0) ? 7'h20 : {3'b011, b[11:8]};
        t = (b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 7'h20 : {3'b011, b[7:4]};
        u = {3'b011, b[3:0]};
        return {h, t, u};
    endfunction

    assign work_step = dd_step(work);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (score_update) state_nx = CONV_P;
            CONV_P:     if (iter == 3'd7) state_nx = CONV_C;
            CONV_C:     if (iter == 3'd7) state_nx = FORMAT;
            FORMAT:     state_nx = WAIT_VBLNK;
            WAIT_VBLNK: if (vblnk) state_nx = COMMIT;
            COMMIT:     state_nx = (pending || score_update) ? CONV_P : IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= '0;
            iter     <= '0;
            cpu_lat  <= '0;
            bcd_p    <= '0;
            pend_p   <= '0;
            pend_c   <= '0;
            pending  <= 1'b0;
            shadow_p <= DIGITS_RST;
            shadow_c <= DIGITS_RST;
            disp_p   <= DIGITS_RST;
            disp_c   <= DIGITS_RST;
        end else begin
            if (score_update && state != IDLE && state != COMMIT) begin
                pend_p  <= score_player;
                pend_c  <= score_cpu;
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (score_update) begin
                        work    <= {12'd0, score_player};
                        cpu_lat <= score_cpu;
                        iter    <= '0;
                    end
                end
                CONV_P: begin
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        bcd_p <= work_step[19:8];
                        work  <= {12'd0, cpu_lat};
                    end else begin
                        work  <= work_step;
                    end
                end
                CONV_C: begin
                    iter <= iter + 3'd1;
                    work <= work_step;
                end
                FORMAT: begin
                    shadow_p <= fmt(bcd_p);
                    shadow_c <= fmt(work[19:8]);
                end
                COMMIT: begin
                    disp_p  <= shadow_p;
                    disp_c  <= shadow_c;
                    iter    <= '0;
                    pending <= 1'b0;
                    // A request arriving in this very cycle is newer than anything pending.
                    if (score_update) begin
                        work    <= {12'd0, score_player};
                        cpu_lat <= score_cpu;
                    end else if (pending) begin
                        work    <= {12'd0, pend_p};
                        cpu_lat <= pend_c;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [3:0] rd_row;
    logic [7:0] rd_col, off;
    logic [6:0] code_nx;

    always_comb begin
        rd_row  = char_xy[11:8];
        rd_col  = char_xy[7:0];
        off     = '0;
        code_nx = 7'h20;
        if (rd_row < 4'd8 && rd_row == ROW && rd_col < 8'd32) begin
            if (rd_col >= P_LBL && rd_col < P_LBL + 8'd4) begin
                off = rd_col - P_LBL;
                case (off[1:0])
                    2'd0:    code_nx = 7'h59;
                    2'd1:    code_nx = 7'h4F;
                    2'd2:    code_nx = 7'h55;
                    default: code_nx = 7'h3A;
                endcase
            end else if (rd_col >= C_LBL && rd_col < C_LBL + 8'd4) begin
                off = rd_col - C_LBL;
                case (off[1:0])
                    2'd0:    code_nx = 7'h43;
                    2'd1:    code_nx = 7'h50;
                    2'd2:    code_nx = 7'h55;
                    default: code_nx = 7'h3A;
                endcase
            end else if (rd_col >= P_DIG && rd_col < P_DIG + 8'd3) begin
                off = rd_col - P_DIG;
                case (off[1:0])
                    2'd0:    code_nx = disp_p[20:14];
                    2'd1:    code_nx = disp_p[13:7];
                    default: code_nx = disp_p[6:0];
                endcase
            end else if (rd_col >= C_DIG && rd_col < C_DIG + 8'd3) begin
                off = rd_col - C_DIG;
                case (off[1:0])
                    2'd0:    code_nx = disp_c[20:14];
                    2'd1:    code_nx = disp_c[13:7];
                    default: code_nx = disp_c[6:0];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) char_code <= 7'h20;
        else     char_code <= code_nx;
    end

endmodule

// File: tb/tb_score_text_buffer.sv
// tb/tb_score_text_buffer.sv - scoreboard bench for score_text_buffer
module tb_score_text_buffer;

    localparam logic [7:0] PD = 8'd5;
    localparam logic [7:0] CD = 8'd21;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] char_xy;
    logic [6:0]  char_code;
    logic        vblnk;
    logic        score_update;
    logic [7:0]  score_player;
    logic [7:0]  score_cpu;
    logic        busy;

    score_text_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .char_xy      (char_xy),
        .char_code    (char_code),
        .vblnk        (vblnk),
        .score_update (score_update),
        .score_player (score_player),
        .score_cpu    (score_cpu),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } rd_t;

    rd_t  sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic rd_vld = 1'b0;
    logic rd_vld_q = 1'b0;

    always @(posedge clk) rd_vld_q <= rd_vld;

    // Monitor: a read presented in one cycle appears on char_code in the next.
    always @(negedge clk) begin
        rd_t e;
        if (rd_vld_q) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: read result %h with no expectation queued", char_code);
            end else begin
                e = sb.pop_front();
                if (char_code !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: char_code=%h required=%h", e.name, char_code, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        rd_vld       = 1'b0;
        score_update = 1'b0;
    endtask

    task automatic issue(input logic [3:0] r, input logic [7:0] c, input logic [6:0] e, input string nm);
        rd_t it;
        char_xy = {r, c};
        rd_vld  = 1'b1;
        it.name = nm;
        it.exp  = e;
        sb.push_back(it);
    endtask

    task automatic rd(input logic [3:0] r, input logic [7:0] c, input logic [6:0] e, input string nm);
        issue(r, c, e, nm);
        tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d required=%0d", nm, got, exp);
        end
    endtask

    task automatic req(input logic [7:0] p, input logic [7:0] c);
        score_player = p;
        score_cpu    = c;
        score_update = 1'b1;
    endtask

    task automatic rd_digits(input logic [20:0] p, input logic [20:0] c, input string nm);
        rd(4'd0, PD,        p[20:14], {nm, "_p0"});
        rd(4'd0, PD + 8'd1, p[13:7],  {nm, "_p1"});
        rd(4'd0, PD + 8'd2, p[6:0],   {nm, "_p2"});
        rd(4'd0, CD,        c[20:14], {nm, "_c0"});
        rd(4'd0, CD + 8'd1, c[13:7],  {nm, "_c1"});
        rd(4'd0, CD + 8'd2, c[6:0],   {nm, "_c2"});
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (busy && cyc < limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [6:0] row0_exp [8] = '{7'h59, 7'h4F, 7'h55, 7'h3A, 7'h20, 7'h20, 7'h20, 7'h30};
    logic [6:0] cpu_lbl  [4] = '{7'h43, 7'h50, 7'h55, 7'h3A};
    logic [7:0] pend_col [6] = '{8'd5, 8'd6, 8'd7, 8'd21, 8'd22, 8'd23};
    logic [6:0] pend_exp [6] = '{7'h20, 7'h31, 7'h30, 7'h20, 7'h32, 7'h30};

    initial begin
        int cyc;
        int bad;
        rst          = 1'b1;
        vblnk        = 1'b1;
        score_update = 1'b0;
        score_player = '0;
        score_cpu    = '0;
        char_xy      = 12'h000;
        repeat (3) tick();
        chk("reset_char_code", {25'd0, char_code}, 32'h20);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) rd(4'd0, 8'(i), row0_exp[i], "reset_row0");
        for (int i = 0; i < 4; i++) rd(4'd0, 8'(16 + i), cpu_lbl[i], "cpu_label");
        rd_digits({7'h20, 7'h20, 7'h30}, {7'h20, 7'h20, 7'h30}, "reset_digits");

        // Basic update with vblnk high: busy must be low exactly 20 cycles after the request.
        req(8'd7, 8'd123);
        wait_idle(100, cyc);
        chk("busy_fall_latency", cyc, 32'd20);
        rd_digits({7'h20, 7'h20, 7'h37}, {7'h31, 7'h32, 7'h33}, "basic");

        // Blank gating.
        vblnk = 1'b0;
        req(8'd255, 8'd0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy) bad++;
            if (i == 100) rd_digits({7'h20, 7'h20, 7'h37}, {7'h31, 7'h32, 7'h33}, "blank_old");
        end
        chk("blank_busy_held", bad, 32'd0);
        vblnk = 1'b1;
        wait_idle(10, cyc);
        chk("blank_release_idle", {31'd0, busy}, 32'd0);
        rd_digits({7'h32, 7'h35, 7'h35}, {7'h20, 7'h20, 7'h30}, "blank_new");

        // Pending update arriving mid-conversion.
        req(8'd10, 8'd20);
        bad = 0;
        for (int c = 1; c <= 42; c++) begin
            tick();
            if (c <= 38 && !busy) bad++;
            if (c == 39) chk("pend_busy_fall", {31'd0, busy}, 32'd0);
            if (c == 5) req(8'd42, 8'd99);
            if (c >= 21 && c <= 26) issue(4'd0, pend_col[c-21], pend_exp[c-21], "pend_first");
        end
        chk("pend_busy_continuous", bad, 32'd0);
        rd_digits({7'h20, 7'h34, 7'h32}, {7'h20, 7'h39, 7'h39}, "pend_second");

        // Out-of-range addresses.
        rd(4'd9, 8'd0,  7'h20, "oor_row9_col0");
        rd(4'd9, 8'd6,  7'h20, "oor_row9_col6");
        rd(4'd8, 8'd6,  7'h20, "oor_row8_col6");
        rd(4'd0, 8'd40, 7'h20, "oor_col40");
        rd(4'd0, 8'd38, 7'h20, "oor_col38");
        rd(4'd0, 8'd31, 7'h20, "blank_col31");
        rd(4'd1, 8'd0,  7'h20, "blank_row1");

        // Reset in the middle of a conversion.
        req(8'd200, 8'd201);
        for (int c = 1; c <= 10; c++) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        rd_digits({7'h20, 7'h20, 7'h30}, {7'h20, 7'h20, 7'h30}, "rst_mid_digits");
        repeat (30) tick();
        chk("rst_mid_no_resume", {31'd0, busy}, 32'd0);
        rd_digits({7'h20, 7'h20, 7'h30}, {7'h20, 7'h20, 7'h30}, "rst_mid_late");

        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
